// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stage reset/enable controller for the 5-stage MIPS pipeline:
//               reset sequencing, RAW stalls, branch flushes, memory freeze,
//               debug halt/step, stall/flush statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int INIT_CYCLES       = 4,
    parameter int REGFILE_WB_BYPASS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        debug_halt,
    input  logic        debug_step,
    input  logic [31:0] inst_data_id,
    input  logic        id_valid,
    input  logic        rs_used_id,
    input  logic        rt_used_id,
    input  logic [4:0]  regw_addr_exe,
    input  logic        wb_wen_exe,
    input  logic [4:0]  regw_addr_mem,
    input  logic        wb_wen_mem,
    input  logic [4:0]  regw_addr_wb,
    input  logic        wb_wen_wb,
    input  logic        is_branch_exe,
    input  logic        is_branch_mem,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        mem_ack,
    output logic        if_rst,
    output logic        if_en,
    output logic        id_rst,
    output logic        id_en,
    output logic        exe_rst,
    output logic        exe_en,
    output logic        mem_rst,
    output logic        mem_en,
    output logic        wb_rst,
    output logic        wb_en,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_STEP = 2'd3
    } state_t;

    localparam logic [3:0] c_INIT_LOAD = 4'(INIT_CYCLES - 1);
    localparam logic       c_WB_HAZ_EN = (REGFILE_WB_BYPASS == 0);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_init_cnt;

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_hz_exe;
    logic       w_hz_mem;
    logic       w_hz_wb;
    logic       w_raw;
    logic       w_mem_busy;
    logic       w_stall;
    logic       w_flush;
    logic       w_unused_bits;

    assign w_rs = inst_data_id[25:21];
    assign w_rt = inst_data_id[20:16];
    assign w_unused_bits = ^{inst_data_id[31:26], inst_data_id[15:0]};

    assign w_hz_exe = id_valid & wb_wen_exe & (regw_addr_exe != 5'd0) &
                      ((rs_used_id & (regw_addr_exe == w_rs)) |
                       (rt_used_id & (regw_addr_exe == w_rt)));
    assign w_hz_mem = id_valid & wb_wen_mem & (regw_addr_mem != 5'd0) &
                      ((rs_used_id & (regw_addr_mem == w_rs)) |
                       (rt_used_id & (regw_addr_mem == w_rt)));
    assign w_hz_wb  = id_valid & wb_wen_wb & (regw_addr_wb != 5'd0) &
                      ((rs_used_id & (regw_addr_wb == w_rs)) |
                       (rt_used_id & (regw_addr_wb == w_rt)));

    assign w_raw      = w_hz_exe | w_hz_mem | (c_WB_HAZ_EN & w_hz_wb);
    assign w_mem_busy = (mem_ren | mem_wen) & ~mem_ack;
    assign halted     = (r_state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_init_cnt <= c_INIT_LOAD;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT && r_init_cnt != 4'd0) begin
                r_init_cnt <= r_init_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if_rst  = 1'b0;  if_en  = 1'b0;
        id_rst  = 1'b0;  id_en  = 1'b0;
        exe_rst = 1'b0;  exe_en = 1'b0;
        mem_rst = 1'b0;  mem_en = 1'b0;
        wb_rst  = 1'b0;  wb_en  = 1'b0;
        w_stall = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            S_INIT: begin
                if_rst = 1'b1; id_rst = 1'b1; exe_rst = 1'b1;
                mem_rst = 1'b1; wb_rst = 1'b1;
                if (r_init_cnt == 4'd0) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HALT: begin
                // A step request wins over releasing the halt.
                if (debug_step) begin
                    w_state_nxt = S_STEP;
                end else if (!debug_halt) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                if (r_state == S_RUN) begin
                    if (debug_halt) w_state_nxt = S_HALT;
                end else if (!w_mem_busy) begin
                    w_state_nxt = S_HALT;
                end
                // Branch rows precede raw: the ID instruction is wrong-path.
                if (w_mem_busy) begin
                    w_stall = 1'b1;
                end else if (is_branch_mem) begin
                    w_flush = 1'b1;
                    if_en = 1'b1; id_en = 1'b1; id_rst = 1'b1;
                    exe_en = 1'b1; mem_en = 1'b1; wb_en = 1'b1;
                end else if (is_branch_exe) begin
                    w_flush = 1'b1;
                    id_en = 1'b1; id_rst = 1'b1;
                    exe_en = 1'b1; mem_en = 1'b1; wb_en = 1'b1;
                end else if (w_raw) begin
                    w_stall = 1'b1;
                    exe_rst = 1'b1; exe_en = 1'b1;
                    mem_en = 1'b1; wb_en = 1'b1;
                end else begin
                    if_en = 1'b1; id_en = 1'b1; exe_en = 1'b1;
                    mem_en = 1'b1; wb_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (w_stall && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (w_flush && flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        debug_halt, debug_step;
    logic [31:0] inst_data_id;
    logic        id_valid, rs_used_id, rt_used_id;
    logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic        wb_wen_exe, wb_wen_mem, wb_wen_wb;
    logic        is_branch_exe, is_branch_mem;
    logic        mem_ren, mem_wen, mem_ack;
    logic        if_rst, if_en, id_rst, id_en, exe_rst, exe_en;
    logic        mem_rst, mem_en, wb_rst, wb_en, halted;
    logic [31:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // {if_rst,if_en,id_rst,id_en,exe_rst,exe_en,mem_rst,mem_en,wb_rst,wb_en}
    localparam logic [9:0] c_ALL_RST = 10'b10_10_10_10_10;
    localparam logic [9:0] c_ALL_EN  = 10'b01_01_01_01_01;
    localparam logic [9:0] c_FROZEN  = 10'b00_00_00_00_00;
    localparam logic [9:0] c_BR_MEM  = 10'b01_11_01_01_01;
    localparam logic [9:0] c_BR_EXE  = 10'b00_10_01_01_01;
    localparam logic [9:0] c_BR_EXE_MASK = 10'b11_10_11_11_11;
    localparam logic [9:0] c_RAW     = 10'b00_00_10_01_01;
    localparam logic [9:0] c_RAW_MASK    = 10'b11_11_10_11_11;
    localparam logic [31:0] c_ADD_3_1_2  = 32'h0022_1820;

    logic [9:0] ctrl;
    assign ctrl = {if_rst, if_en, id_rst, id_en, exe_rst, exe_en,
                   mem_rst, mem_en, wb_rst, wb_en};

    always #5 clk = ~clk;

    pipeline_ctrl #(.INIT_CYCLES(4), .REGFILE_WB_BYPASS(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .debug_halt(debug_halt), .debug_step(debug_step),
        .inst_data_id(inst_data_id), .id_valid(id_valid),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
        .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
        .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_ack(mem_ack),
        .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
        .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
        .wb_rst(wb_rst), .wb_en(wb_en), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 3ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_hazards();
        id_valid = 1'b0; rs_used_id = 1'b0; rt_used_id = 1'b0;
        inst_data_id = 32'd0;
        regw_addr_exe = 5'd0; regw_addr_mem = 5'd0; regw_addr_wb = 5'd0;
        wb_wen_exe = 1'b0; wb_wen_mem = 1'b0; wb_wen_wb = 1'b0;
        is_branch_exe = 1'b0; is_branch_mem = 1'b0;
        mem_ren = 1'b0; mem_wen = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        debug_halt = 1'b0;
        debug_step = 1'b0;
        clear_hazards();

        // Reset held for three cycles
        repeat (3) next_cycle();
        check("reset_ctrl", 32'(ctrl), 32'(c_ALL_RST));
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_stall", stall_cnt, 32'd0);
        check("reset_flush", flush_cnt, 32'd0);

        // Exactly four INIT cycles after release
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("init_rst_%0d", i), 32'(ctrl), 32'(c_ALL_RST));
            next_cycle();
        end
        settle();
        check("run_after_init", 32'(ctrl), 32'(c_ALL_EN));
        check("run_counters", stall_cnt | flush_cnt, 32'd0);

        // RAW against EXE, then MEM, then WB
        next_cycle();
        inst_data_id = c_ADD_3_1_2;
        id_valid = 1'b1; rs_used_id = 1'b1; rt_used_id = 1'b1;
        regw_addr_exe = 5'd1; wb_wen_exe = 1'b1;
        settle();
        check("raw_exe", 32'(ctrl & c_RAW_MASK), 32'(c_RAW));
        next_cycle();
        regw_addr_exe = 5'd0; wb_wen_exe = 1'b0;
        regw_addr_mem = 5'd1; wb_wen_mem = 1'b1;
        settle();
        check("raw_mem", 32'(ctrl & c_RAW_MASK), 32'(c_RAW));
        next_cycle();
        regw_addr_mem = 5'd0; wb_wen_mem = 1'b0;
        regw_addr_wb = 5'd2; wb_wen_wb = 1'b1;
        settle();
        check("raw_wb", 32'(ctrl & c_RAW_MASK), 32'(c_RAW));
        next_cycle();
        regw_addr_wb = 5'd0; wb_wen_wb = 1'b0;
        settle();
        check("raw_cleared", 32'(ctrl), 32'(c_ALL_EN));
        check("stall_cnt_raw", stall_cnt, 32'd3);

        // Branch in EXE then MEM with a simultaneous RAW hazard
        next_cycle();
        regw_addr_exe = 5'd2; wb_wen_exe = 1'b1;
        is_branch_exe = 1'b1;
        settle();
        check("branch_exe", 32'(ctrl & c_BR_EXE_MASK), 32'(c_BR_EXE));
        next_cycle();
        is_branch_exe = 1'b0; is_branch_mem = 1'b1;
        settle();
        check("branch_mem", 32'(ctrl), 32'(c_BR_MEM));
        next_cycle();
        clear_hazards();
        settle();
        check("flush_cnt", flush_cnt, 32'd2);
        check("stall_after_branch", stall_cnt, 32'd3);

        // Slow memory: three busy cycles then ack
        mem_ren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("mem_freeze_%0d", i), 32'(ctrl), 32'(c_FROZEN));
            next_cycle();
        end
        mem_ack = 1'b1;
        settle();
        check("mem_ack_run", 32'(ctrl), 32'(c_ALL_EN));
        check("stall_cnt_mem", stall_cnt, 32'd6);
        next_cycle();
        clear_hazards();

        // Debug halt, single step, release
        debug_halt = 1'b1;
        settle();
        check("halt_req_cycle", 32'(ctrl), 32'(c_ALL_EN));
        check("halt_req_halted", 32'(halted), 32'd0);
        next_cycle();
        settle();
        check("halted", 32'(halted), 32'd1);
        check("halted_ctrl", 32'(ctrl), 32'(c_FROZEN));
        next_cycle();
        debug_step = 1'b1;
        settle();
        check("step_req_halted", 32'(halted), 32'd1);
        next_cycle();
        debug_step = 1'b0;
        settle();
        check("step_ctrl", 32'(ctrl), 32'(c_ALL_EN));
        check("step_halted", 32'(halted), 32'd0);
        next_cycle();
        settle();
        check("rehalted", 32'(halted), 32'd1);
        check("rehalted_ctrl", 32'(ctrl), 32'(c_FROZEN));
        next_cycle();
        debug_halt = 1'b0;
        settle();
        check("release_cycle", 32'(halted), 32'd1);
        next_cycle();
        settle();
        check("resumed", 32'(ctrl), 32'(c_ALL_EN));
        check("resumed_halted", 32'(halted), 32'd0);

        // Register $0 and invalid ID never stall
        next_cycle();
        inst_data_id = 32'h0000_1820;
        id_valid = 1'b1; rs_used_id = 1'b1; rt_used_id = 1'b1;
        regw_addr_exe = 5'd0; wb_wen_exe = 1'b1;
        settle();
        check("zero_reg", 32'(ctrl), 32'(c_ALL_EN));
        next_cycle();
        inst_data_id = c_ADD_3_1_2;
        id_valid = 1'b0;
        regw_addr_exe = 5'd1;
        settle();
        check("id_invalid", 32'(ctrl), 32'(c_ALL_EN));
        next_cycle();
        clear_hazards();
        settle();
        check("final_stall", stall_cnt, 32'd6);
        check("final_flush", flush_cnt, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
